fp32_divider: RTL and testbench
===============================

Name: fp32_divider

Overview:
- Sequential IEEE-754 single-precision divider (result = a / b).
- Companion to the combinational fp32 multiplier; used by the neuron datapath for normalisation and learning-rate scaling.
- Restoring mantissa division, one quotient bit per clock.
- Start/done handshake with fixed latency, so the scheduler can pipeline around it.

Parameters:
ROUND_NEAREST, 0, 0 = round toward zero (truncate, matches multiplier); 1 = round to nearest, ties to even
LATENCY, 29, cycles from start acceptance to done pulse; fixed by architecture, not user-tunable

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  request; sampled only when idle
a  input  32  dividend, IEEE-754 single
b  input  32  divisor, IEEE-754 single
busy  output  1  high while an operation is in flight
done  output  1  one-cycle pulse: result/flags valid
result  output  32  quotient, IEEE-754 single
ovf  output  1  exponent overflow, result forced to signed infinity
div_by_zero  output  1  finite nonzero or infinite a divided by zero b

Behaviour:
- Reset (rst_n=0 at rising edge): state IDLE; busy=0, done=0, result=0, ovf=0, div_by_zero=0.
- Reset mid-operation aborts the operation with no done pulse.
- FSM states and transitions:
  - IDLE: start=1 captures a, b -> UNPACK.
  - UNPACK: 1 cycle -> DIVIDE.
  - DIVIDE: 26 cycles -> NORM.
  - NORM: 1 cycle -> DONE.
  - DONE: 1 cycle -> IDLE.
- Timing: busy=1 in UNPACK..NORM. done=1 only in DONE, exactly 29 cycles after the start-sample cycle; busy=0 during DONE.
- start while busy is ignored; operands are not re-captured.
- start asserted during the DONE cycle is accepted (back-to-back throughput of one op per 29 cycles).
- result, ovf and div_by_zero update only on entry to DONE and hold until the next DONE or reset.
- Unpack:
  - sign = a[31]^b[31]; ea, eb 8-bit.
  - Mantissa {1,frac} for normal operands.
  - Exponent field 0 (zero or denormal) is treated as zero: denormals are flushed.
- Division:
  - Compute q = floor(ma*2^25/mb), 26 bits, with remainder rem.
  - If q[25]=1: mant = q[25:2], guard = q[1], sticky = q[0] | (rem!=0), e = ea-eb+127.
  - Otherwise: mant = q[24:1], guard = q[0], sticky = (rem!=0), e = ea-eb+126.
  - e is a signed 10-bit value.
- Rounding:
  - ROUND_NEAREST=0: drop guard and sticky.
  - ROUND_NEAREST=1: increment when guard & (sticky | mant[0]).
  - A mantissa carry-out renormalises (mant>>1, e+1) before range checks.
- Range:
  - e >= 255: result = {sign, 0xFF, 0}, ovf=1.
  - e <= 0: result = {sign, 31'b0} (flush to zero), ovf=0.
- Special cases take the same fixed latency; input priority is top to bottom:
  - Either input NaN, 0/0, or inf/inf: result 0x7FC00000, flags 0.
  - Finite nonzero or inf divided by 0: signed inf, div_by_zero=1.
  - inf / finite: signed inf, ovf=0.
  - 0 / nonzero, or finite / inf: signed zero.

Test Plan:
- a=0x40C00000, b=0x40000000, start 1 cycle -> done exactly 29 cycles later; result 0x40400000 (3.0); ovf=0, div_by_zero=0; busy high for 28 cycles.
- a=0x3F800000, b=0x40400000 (1/3) -> ROUND_NEAREST=0 gives 0x3EAAAAAA; ROUND_NEAREST=1 gives 0x3EAAAAAB.
- a=0x7F000000, b=0x3E800000 -> result 0x7F800000, ovf=1. a=0x00800000, b=0x40000000 -> result 0x00000000 (underflow flush), ovf=0.
- a=0xC0000000, b=0x00000000 -> 0xFF800000, div_by_zero=1. a=0, b=0 -> 0x7FC00000. a=0x7FC00000, b=0x3F800000 -> 0x7FC00000.
- Start op A (6/2). Pulse start with other operands at cycle 10 -> ignored; A's result 0x40400000 delivered. Start op B (1/3) in A's DONE cycle -> B done 29 cycles later.
- Start 6/2, drive rst_n=0 at cycle 12 -> no done pulse, all outputs 0. New start after reset completes normally.

Source files
------------

// File: rtl/fp32_divider.sv
// rtl/fp32_divider.sv - sequential IEEE-754 single-precision divider, one quotient bit per clock
module fp32_divider #(
  parameter int ROUND_NEAREST = 0,
  parameter int LATENCY       = 29
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        ovf,
  output logic        div_by_zero
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_DIVIDE,
    S_NORM,
    S_DONE
  } state_t;

  // special-case classes resolved during unpack, applied at normalisation
  localparam logic [2:0] K_NORMAL = 3'd0;
  localparam logic [2:0] K_NAN    = 3'd1;
  localparam logic [2:0] K_DBZ    = 3'd2;
  localparam logic [2:0] K_INF    = 3'd3;
  localparam logic [2:0] K_ZERO   = 3'd4;

  // DIVIDE occupies whatever is left of the latency after UNPACK, NORM and DONE
  localparam logic [4:0] DIV_LAST = 5'(LATENCY - 4);

  state_t             state, state_nxt;
  logic               accept;
  logic [31:0]        a_r, b_r;
  logic               sign_r;
  logic signed [9:0]  e_base_r;
  logic [23:0]        mb_r;
  logic [24:0]        rem_r;
  logic [25:0]        q_r;
  logic [4:0]         cnt_r;
  logic [2:0]         kind_r;

  // unpack view of the captured operands
  logic [7:0]  ea, eb;
  logic        za, zb, ia, ib, na, nb;
  logic [2:0]  kind_u;

  // restoring step and normalisation
  logic        ge;
  logic [24:0] r_sub;
  logic [23:0] mant;
  logic        guard, sticky, rnd;
  logic signed [9:0] e_n, e_f;
  logic [24:0] mant_r;
  logic [22:0] frac_f;
  logic [31:0] res_n;
  logic        ovf_n, dbz_n;

  assign accept = start && (state == S_IDLE || state == S_DONE);
  assign busy   = (state == S_UNPACK) || (state == S_DIVIDE) || (state == S_NORM);
  assign done   = (state == S_DONE);

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // next-state: fixed-length walk through the phases, new op accepted in IDLE or DONE
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_UNPACK;
      S_UNPACK: state_nxt = S_DIVIDE;
      S_DIVIDE: if (cnt_r == DIV_LAST) state_nxt = S_NORM;
      S_NORM:   state_nxt = S_DONE;
      S_DONE:   state_nxt = start ? S_UNPACK : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // operand classification; exponent field zero counts as zero so denormals flush
  always_comb begin
    ea = a_r[30:23];
    eb = b_r[30:23];
    za = (ea == 8'd0);
    zb = (eb == 8'd0);
    ia = (ea == 8'hFF) && (a_r[22:0] == 23'd0);
    ib = (eb == 8'hFF) && (b_r[22:0] == 23'd0);
    na = (ea == 8'hFF) && (a_r[22:0] != 23'd0);
    nb = (eb == 8'hFF) && (b_r[22:0] != 23'd0);
    kind_u = K_NORMAL;
    if (na || nb || (za && zb) || (ia && ib)) kind_u = K_NAN;
    else if (zb)                              kind_u = K_DBZ;
    else if (ia)                              kind_u = K_INF;
    else if (za || ib)                        kind_u = K_ZERO;
  end

  // one restoring subtraction per cycle; remainder is pre-doubled for the next bit
  always_comb begin
    ge    = (rem_r >= {1'b0, mb_r});
    r_sub = ge ? (rem_r - {1'b0, mb_r}) : rem_r;
  end

  // normalise, round, renormalise on carry, then range-check and apply special cases
  always_comb begin
    if (q_r[25]) begin
      mant   = q_r[25:2];
      guard  = q_r[1];
      sticky = q_r[0] | (rem_r != 25'd0);
      e_n    = e_base_r + 10'sd1;
    end else begin
      mant   = q_r[24:1];
      guard  = q_r[0];
      sticky = (rem_r != 25'd0);
      e_n    = e_base_r;
    end
    rnd    = (ROUND_NEAREST != 0) && guard && (sticky || mant[0]);
    mant_r = {1'b0, mant} + {24'd0, rnd};
    if (mant_r[24]) begin
      frac_f = mant_r[23:1];
      e_f    = e_n + 10'sd1;
    end else begin
      frac_f = mant_r[22:0];
      e_f    = e_n;
    end
    ovf_n = 1'b0;
    dbz_n = 1'b0;
    if (e_f >= 10'sd255) begin
      res_n = {sign_r, 8'hFF, 23'd0};
      ovf_n = 1'b1;
    end else if (e_f <= 10'sd0) begin
      res_n = {sign_r, 31'd0};
    end else begin
      res_n = {sign_r, e_f[7:0], frac_f};
    end
    case (kind_r)
      K_NAN: begin
        res_n = 32'h7FC00000;
        ovf_n = 1'b0;
      end
      K_DBZ: begin
        res_n = {sign_r, 8'hFF, 23'd0};
        ovf_n = 1'b0;
        dbz_n = 1'b1;
      end
      K_INF: begin
        res_n = {sign_r, 8'hFF, 23'd0};
        ovf_n = 1'b0;
      end
      K_ZERO: begin
        res_n = {sign_r, 31'd0};
        ovf_n = 1'b0;
      end
      default: ;
    endcase
  end

  // datapath: capture, unpack, iterate, and publish results on entry to DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r         <= 32'd0;
      b_r         <= 32'd0;
      sign_r      <= 1'b0;
      e_base_r    <= 10'sd0;
      mb_r        <= 24'd0;
      rem_r       <= 25'd0;
      q_r         <= 26'd0;
      cnt_r       <= 5'd0;
      kind_r      <= K_NORMAL;
      result      <= 32'd0;
      ovf         <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      if (accept) begin
        a_r <= a;
        b_r <= b;
      end
      case (state)
        S_UNPACK: begin
          sign_r   <= a_r[31] ^ b_r[31];
          e_base_r <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd126;
          mb_r     <= {1'b1, b_r[22:0]};
          rem_r    <= {2'b01, a_r[22:0]};
          q_r      <= 26'd0;
          cnt_r    <= 5'd0;
          kind_r   <= kind_u;
        end
        S_DIVIDE: begin
          q_r   <= {q_r[24:0], ge};
          rem_r <= r_sub << 1;
          cnt_r <= cnt_r + 5'd1;
        end
        S_NORM: begin
          result      <= res_n;
          ovf         <= ovf_n;
          div_by_zero <= dbz_n;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_divider.sv
// tb/tb_fp32_divider.sv - directed-vector bench for fp32_divider (truncating and round-to-nearest)
module tb_fp32_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy0, done0, ovf0, dbz0;
  logic        busy1, done1, ovf1, dbz1;
  logic [31:0] result0, result1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fp32_divider #(.ROUND_NEAREST(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy0), .done(done0), .result(result0), .ovf(ovf0), .div_by_zero(dbz0)
  );

  fp32_divider #(.ROUND_NEAREST(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy1), .done(done1), .result(result1), .ovf(ovf1), .div_by_zero(dbz1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // called at the negedge just after the start-sample edge; returns at the DONE negedge
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 1;
    busy_cnt = busy0 ? 1 : 0;
    while (!done0 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy0) busy_cnt++;
    end
  endtask

  task automatic do_op(input logic [31:0] av, input logic [31:0] bv, output int lat, output int busy_cnt);
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, busy_cnt);
  endtask

  localparam int NV = 11;
  logic [31:0] va   [NV] = '{32'h40C00000, 32'h3F800000, 32'h7F000000, 32'h00800000, 32'hC0000000,
                             32'h00000000, 32'h7FC00000, 32'h7F800000, 32'h3F800000, 32'h80000000,
                             32'hC1200000};
  logic [31:0] vb   [NV] = '{32'h40000000, 32'h40400000, 32'h3E800000, 32'h40000000, 32'h00000000,
                             32'h00000000, 32'h3F800000, 32'h40000000, 32'h7F800000, 32'h40000000,
                             32'h40A00000};
  logic [31:0] vr0  [NV] = '{32'h40400000, 32'h3EAAAAAA, 32'h7F800000, 32'h00000000, 32'hFF800000,
                             32'h7FC00000, 32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h80000000,
                             32'hC0000000};
  logic [31:0] vr1  [NV] = '{32'h40400000, 32'h3EAAAAAB, 32'h7F800000, 32'h00000000, 32'hFF800000,
                             32'h7FC00000, 32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h80000000,
                             32'hC0000000};
  logic        vovf [NV] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
  logic        vdbz [NV] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};

  initial begin
    int lat;
    int bc;
    int cyc;
    int pulses;

    repeat (3) @(negedge clk);
    check("rst_busy",   {31'd0, busy0}, 32'd0);
    check("rst_done",   {31'd0, done0}, 32'd0);
    check("rst_result", result0, 32'd0);
    check("rst_ovf",    {31'd0, ovf0}, 32'd0);
    check("rst_dbz",    {31'd0, dbz0}, 32'd0);
    check("rst_busy1",  {31'd0, busy1}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      do_op(va[i], vb[i], lat, bc);
      check($sformatf("v%0d_latency", i), lat, 29);
      check($sformatf("v%0d_busy_cycles", i), bc, 28);
      check($sformatf("v%0d_busy_in_done", i), {31'd0, busy0}, 32'd0);
      check($sformatf("v%0d_done_rn", i), {31'd0, done1}, 32'd1);
      check($sformatf("v%0d_result_rz", i), result0, vr0[i]);
      check($sformatf("v%0d_result_rn", i), result1, vr1[i]);
      check($sformatf("v%0d_ovf", i), {31'd0, ovf0}, {31'd0, vovf[i]});
      check($sformatf("v%0d_dbz", i), {31'd0, dbz0}, {31'd0, vdbz[i]});
      check($sformatf("v%0d_ovf_rn", i), {31'd0, ovf1}, {31'd0, vovf[i]});
      check($sformatf("v%0d_dbz_rn", i), {31'd0, dbz1}, {31'd0, vdbz[i]});
      @(negedge clk);
      check($sformatf("v%0d_done_one_cycle", i), {31'd0, done0}, 32'd0);
      check($sformatf("v%0d_result_hold", i), result0, vr0[i]);
    end

    // op A = 6/2, spurious start with 1/3 at cycle 10, op B = 1/3 started in A's DONE cycle
    @(negedge clk);
    a = 32'h40C00000;
    b = 32'h40000000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    a = 32'h3F800000;
    b = 32'h40400000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc++;
    while (!done0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("ignored_start_latency", cyc, 29);
    check("ignored_start_result", result0, 32'h40400000);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc);
    check("b2b_latency", lat, 29);
    check("b2b_result_rz", result0, 32'h3EAAAAAA);
    check("b2b_result_rn", result1, 32'h3EAAAAAB);

    // reset at cycle 12 of an operation aborts it
    @(negedge clk);
    a = 32'h40C00000;
    b = 32'h40000000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy",   {31'd0, busy0}, 32'd0);
    check("abort_result", result0, 32'd0);
    check("abort_ovf",    {31'd0, ovf0}, 32'd0);
    check("abort_dbz",    {31'd0, dbz0}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      if (done0) pulses++;
    end
    check("abort_no_done", pulses, 0);
    do_op(32'h40C00000, 32'h40000000, lat, bc);
    check("post_reset_latency", lat, 29);
    check("post_reset_result", result0, 32'h40400000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
